softmax_norm_seq: RTL and testbench

//  Downstream consumer of the reciprocal_pwl stage in the pseudo-softmax datapath.
//  - Collects a vector of N 8-bit pseudo-exponent values and accumulates their sum.
//  - Normalises the sum to an 8-bit mantissa and drives it into reciprocal_pwl.
//  - Captures the reciprocal, multiplies each buffered element by it and streams
//    the normalised probabilities out with a valid/ready handshake.

---
 rtl/softmax_norm_seq.sv | 153 +++++++++++++++
 tb/tb_softmax_norm_seq.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/softmax_norm_seq.sv
// Pseudo-softmax normaliser: buffers N exponent values, normalises their sum for
// reciprocal_pwl, then streams each element scaled by the returned reciprocal.
//
// state | meaning
// LOAD  | accept N input elements, accumulate sum
// NORM  | find leading one of sum, drive aligned mantissa to reciprocal_pwl
// WAIT  | let reciprocal_pwl settle for RECIP_LAT cycles, latch its result
// EMIT  | stream scaled elements with valid/ready, last on element N-1
module softmax_norm_seq #(
    parameter int N         = 4,
    parameter int RECIP_LAT = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] in_data,
    output logic [7:0] recip_in,
    input  logic [7:0] recip_out,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] out_data,
    output logic       out_last,
    output logic       busy
);

    localparam int IW = $clog2(N);
    localparam int SW = 8 + IW;
    localparam int CW = (RECIP_LAT > 1) ? $clog2(RECIP_LAT) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);

    typedef enum logic [1:0] {LOAD, NORM, WAIT, EMIT} state_t;

    state_t          state;
    logic [IW-1:0]   idx;
    logic [IW-1:0]   nxt_idx;
    logic [SW-1:0]   sum;
    logic [3:0]      p;
    logic [7:0]      r;
    logic [CW-1:0]   wait_cnt;
    logic            zero_flag;
    logic [7:0]      elem_buf [N];

    function automatic logic [3:0] lead_one(input logic [SW-1:0] v);
        logic [3:0] pos;
        pos = 4'd0;
        for (int i = 0; i < SW; i++)
            if (v[i]) pos = 4'(i);
        return pos;
    endfunction

    // Mantissa with leading one at bit 7; represents m/256.
    function automatic logic [7:0] align(input logic [SW-1:0] v, input logic [3:0] pos);
        logic [SW-1:0] t;
        if (pos < 4'd7) t = v << (4'd7 - pos);
        else            t = v >> (pos - 4'd7);
        return t[7:0];
    endfunction

    function automatic logic [7:0] scale(input logic [7:0] e, input logic [7:0] rr,
                                         input logic [3:0] pos);
        logic [15:0] prod;
        logic [15:0] sh;
        prod = 16'(e) * 16'(rr);
        sh   = prod >> pos;
        return (sh > 16'd255) ? 8'hFF : sh[7:0];
    endfunction

    always_comb begin
        nxt_idx = idx + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= LOAD;
            idx       <= '0;
            sum       <= '0;
            p         <= '0;
            r         <= '0;
            wait_cnt  <= '0;
            zero_flag <= 1'b0;
            recip_in  <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
            busy      <= 1'b0;
            in_ready  <= 1'b1;
        end else begin
            case (state)
                LOAD: begin
                    if (in_valid && in_ready) begin
                        elem_buf[idx] <= in_data;
                        sum           <= sum + SW'(in_data);
                        if (idx == LAST_IDX) begin
                            idx      <= '0;
                            in_ready <= 1'b0;
                            busy     <= 1'b1;
                            state    <= NORM;
                        end else begin
                            idx <= nxt_idx;
                        end
                    end
                end
                NORM: begin
                    p <= lead_one(sum);
                    if (sum == '0) begin
                        // Nothing to normalise: skip the reciprocal round trip entirely.
                        zero_flag <= 1'b1;
                        out_valid <= 1'b1;
                        out_data  <= '0;
                        out_last  <= 1'b0;
                        state     <= EMIT;
                    end else begin
                        recip_in <= align(sum, lead_one(sum));
                        wait_cnt <= CW'(RECIP_LAT - 1);
                        state    <= WAIT;
                    end
                end
                WAIT: begin
                    if (wait_cnt == '0) begin
                        r         <= recip_out;
                        out_valid <= 1'b1;
                        out_data  <= scale(elem_buf[0], recip_out, p);
                        out_last  <= 1'b0;
                        state     <= EMIT;
                    end else begin
                        wait_cnt <= wait_cnt - 1'b1;
                    end
                end
                EMIT: begin
                    if (out_ready) begin
                        if (idx == LAST_IDX) begin
                            idx       <= '0;
                            sum       <= '0;
                            zero_flag <= 1'b0;
                            out_valid <= 1'b0;
                            out_last  <= 1'b0;
                            busy      <= 1'b0;
                            in_ready  <= 1'b1;
                            state     <= LOAD;
                        end else begin
                            idx      <= nxt_idx;
                            out_data <= zero_flag ? 8'd0 : scale(elem_buf[nxt_idx], r, p);
                            out_last <= (nxt_idx == LAST_IDX);
                        end
                    end
                end
                default: state <= LOAD;
            endcase
        end
    end

endmodule

// File: tb/tb_softmax_norm_seq.sv
// Directed-vector bench for softmax_norm_seq (N=4, RECIP_LAT=1) with a simple
// reciprocal_pwl stand-in that answers only for the expected mantissa.
module tb_softmax_norm_seq;

    localparam int N = 4;
    localparam int RECIP_LAT = 1;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic [7:0] recip_in;
    logic [7:0] recip_out;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic       out_last;
    logic       busy;

    logic [7:0] cur_m;
    logic [7:0] cur_r;

    int n_checks = 0;
    int n_pass   = 0;

    softmax_norm_seq #(.N(N), .RECIP_LAT(RECIP_LAT)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .recip_in  (recip_in),
        .recip_out (recip_out),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Reciprocal stand-in: correct answer only when the expected mantissa is presented.
    assign recip_out = (recip_in == cur_m) ? cur_r : 8'd0;

    typedef struct {
        logic [3:0][7:0] din;
        logic [7:0]      r;
        logic [7:0]      m;
        logic [3:0][7:0] dout;
        bit              zero;
        bit              gaps;
        bit              hold;
        int              stall_at;
        bit              pre_rst;
    } vec_t;

    function automatic vec_t mk(input logic [7:0] i0, i1, i2, i3, input logic [7:0] rr, mm,
                                input logic [7:0] o0, o1, o2, o3,
                                input bit z, g, h, input int st, input bit pr);
        vec_t v;
        v.din[0] = i0; v.din[1] = i1; v.din[2] = i2; v.din[3] = i3;
        v.dout[0] = o0; v.dout[1] = o1; v.dout[2] = o2; v.dout[3] = o3;
        v.r = rr; v.m = mm; v.zero = z; v.gaps = g; v.hold = h;
        v.stall_at = st; v.pre_rst = pr;
        return v;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    vec_t vecs [7];

    initial begin
        int tmo;
        int lat;
        int viol;
        int unstable;
        logic [7:0] d0;
        logic       l0;

        //          inputs              r    m    outputs             zero gap hold stall rst
        vecs[0] = mk(0,   0,  0,  0,    77,  0,   0,   0,  0,  0,    1,   0,  0,  -1,   0);
        vecs[1] = mk(64,  64, 64, 64,   255, 128, 63,  63, 63, 63,   0,   0,  0,  -1,   0);
        vecs[2] = mk(200, 0,  0,  0,    164, 200, 255, 0,  0,  0,    0,   0,  0,   1,   0);
        vecs[3] = mk(1,   2,  3,  4,    205, 160, 25,  51, 76, 102,  0,   1,  1,  -1,   0);
        vecs[4] = mk(255, 255,255,255,  129, 255, 64,  64, 64, 64,   0,   0,  0,  -1,   1);
        vecs[5] = mk(10,  20, 30, 40,   164, 200, 25,  51, 76, 102,  0,   0,  1,   2,   0);
        vecs[6] = mk(0,   0,  0,  0,    5,   200, 0,   0,  0,  0,    1,   1,  0,  -1,   0);

        rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        cur_m = 8'd0; cur_r = 8'd0;
        repeat (2) @(negedge clk);
        check("reset_in_ready", int'(in_ready), 1);
        check("reset_busy", int'(busy), 0);
        check("reset_out_valid", int'(out_valid), 0);
        check("reset_recip_in", int'(recip_in), 0);
        rst = 1'b0;

        for (int v = 0; v < 7; v++) begin
            cur_m = vecs[v].m;
            cur_r = vecs[v].r;

            if (vecs[v].pre_rst) begin
                in_valid = 1'b1; in_data = 8'd9;
                repeat (2) @(negedge clk);
                in_valid = 1'b0; rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
                check("rst_mid_in_ready", int'(in_ready), 1);
                check("rst_mid_busy", int'(busy), 0);
                check("rst_mid_recip_in", int'(recip_in), 0);
                check("rst_mid_out_valid", int'(out_valid), 0);
            end

            viol = 0;
            for (int i = 0; i < N; i++) begin
                if (vecs[v].gaps) begin
                    in_valid = 1'b0;
                    repeat (2) @(negedge clk);
                end
                in_valid = 1'b1;
                in_data  = vecs[v].din[i];
                tmo = 0;
                while (!in_ready && tmo < 50) begin
                    @(negedge clk);
                    tmo++;
                end
                if (tmo >= 50) check($sformatf("v%0d_accept_timeout", v), 0, 1);
                @(negedge clk);
            end
            if (vecs[v].hold) in_data = 8'hEE;
            else              in_valid = 1'b0;

            lat = 1;
            while (!out_valid && lat < 40) begin
                if (in_ready) viol++;
                @(negedge clk);
                lat++;
            end
            check($sformatf("v%0d_latency", v), lat, vecs[v].zero ? 2 : 2 + RECIP_LAT);
            check($sformatf("v%0d_busy", v), int'(busy), 1);
            check($sformatf("v%0d_recip_in", v), int'(recip_in), int'(vecs[v].m));

            out_ready = 1'b1;
            for (int k = 0; k < N; k++) begin
                if (k == vecs[v].stall_at) begin
                    out_ready = 1'b0;
                    d0 = out_data; l0 = out_last; unstable = 0;
                    repeat (5) begin
                        @(negedge clk);
                        if (in_ready) viol++;
                        if (!out_valid || out_data != d0 || out_last != l0) unstable++;
                    end
                    check($sformatf("v%0d_stall_stable", v), unstable, 0);
                    out_ready = 1'b1;
                end
                if (in_ready) viol++;
                check($sformatf("v%0d_valid_%0d", v, k), int'(out_valid), 1);
                check($sformatf("v%0d_data_%0d", v, k), int'(out_data), int'(vecs[v].dout[k]));
                check($sformatf("v%0d_last_%0d", v, k), int'(out_last), (k == N - 1) ? 1 : 0);
                if (k == N - 1) in_valid = 1'b0;
                @(negedge clk);
            end
            out_ready = 1'b0;

            check($sformatf("v%0d_in_ready_outside_load", v), viol, 0);
            check($sformatf("v%0d_back_in_load", v), int'(in_ready), 1);
            check($sformatf("v%0d_idle_out_valid", v), int'(out_valid), 0);
            check($sformatf("v%0d_idle_busy", v), int'(busy), 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
